// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the sequential MULT/DIV unit.
package multdiv_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 5;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_NEGA = 3'd2;
   localparam logic [2:0] ST_NEGB = 3'd3;
   localparam logic [2:0] ST_DIV  = 3'd4;
   localparam logic [2:0] ST_NEGQ = 3'd5;
   localparam logic [2:0] ST_DONE = 3'd6;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      MUL  = ST_MUL,
      NEGA = ST_NEGA,
      NEGB = ST_NEGB,
      DIV  = ST_DIV,
      NEGQ = ST_NEGQ,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/multdiv_iter_cnt.sv
// Iteration counter: counts 0..CNT_W-bit max while enabled, wraps to 0,
// flags the last iteration through tc_o.
module multdiv_iter_cnt
   import multdiv_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CNT_W-1:0] count_q;

   // Count enabled iterations; clear takes priority so each operation starts at 0.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign tc_o = en_i && (count_q == {CNT_W{1'b1}});

endmodule

// File: rtl/multdiv_seq.sv
// Multi-cycle signed MULT (radix-2 Booth) / DIV (restoring on magnitudes)
// sequencer. Borrows the ALU's external adder through the as_* ports, one
// add/sub per clock.
module multdiv_seq
   import multdiv_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_mult,
   input  logic             ctrl_div,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             result_rdy,
   output logic             busy,
   output logic [WIDTH-1:0] as_a,
   output logic [WIDTH-1:0] as_b,
   output logic             as_cin,
   input  logic [WIDTH-1:0] as_sum,
   input  logic             as_cout
);

   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q;
   logic [WIDTH-1:0] a_q, a_d;     // Booth accumulator / division remainder
   logic [WIDTH-1:0] q_q, q_d;     // multiplier-product low word / quotient
   logic [WIDTH-1:0] m_q, m_d;     // multiplicand / divisor
   logic             q1_q, q1_d;   // Booth extra bit
   logic             op_q;
   logic             neg_b_q;      // divisor negative: needs NEGB
   logic             neg_q_q;      // signs differ: needs NEGQ
   logic             div_exc_q;    // INT_MIN / -1
   logic [WIDTH-1:0] result_q;
   logic             exception_q;
   logic             result_rdy_q;
   logic             busy_q;

   logic [WIDTH-1:0] a_new;
   logic [WIDTH-1:0] r_shift;
   logic [1:0]       booth;
   logic             exc_fin;
   logic             start;
   logic             cnt_tc;

   assign start = (state_q == IDLE) && (ctrl_mult || ctrl_div);

   multdiv_iter_cnt u_cnt (
      .clock (clock),
      .reset (reset),
      .clr_i (start),
      .en_i  ((state_q == MUL) || (state_q == DIV)),
      .tc_o  (cnt_tc)
   );

   // Drive the shared adder for the current step and form next datapath values.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      as_a    = '0;
      as_b    = '0;
      as_cin  = 1'b0;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      q1_d    = q1_q;
      a_new   = a_q;
      booth   = {q_q[0], q1_q};
      r_shift = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
      unique case (state_q)
         MUL: begin
            as_a   = a_q;
            as_b   = m_q;
            as_cin = (booth == 2'b10);
            if (booth == 2'b10 || booth == 2'b01) a_new = as_sum;
            a_d  = {a_new[WIDTH-1], a_new[WIDTH-1:1]};
            q_d  = {a_new[0], q_q[WIDTH-1:1]};
            q1_d = q_q[0];
         end
         NEGA, NEGQ: begin
            as_b   = q_q;
            as_cin = 1'b1;
            q_d    = as_sum;
         end
         NEGB: begin
            as_b   = m_q;
            as_cin = 1'b1;
            m_d    = as_sum;
         end
         DIV: begin
            as_a   = r_shift;
            as_b   = m_q;
            as_cin = 1'b1;
            if (as_cout) begin
               a_d = as_sum;
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               a_d = r_shift;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
         end
         default: ;
      endcase
      exc_fin = (op_q == OP_MUL) ? (a_d != {WIDTH{q_d[WIDTH-1]}}) : div_exc_q;
   end

   // Sequencer FSM with registered result/handshake outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         a_q          <= '0;
         q_q          <= '0;
         m_q          <= '0;
         q1_q         <= 1'b0;
         op_q         <= OP_MUL;
         neg_b_q      <= 1'b0;
         neg_q_q      <= 1'b0;
         div_exc_q    <= 1'b0;
         result_q     <= '0;
         exception_q  <= 1'b0;
         result_rdy_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         result_rdy_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q      <= 1'b1;
                  exception_q <= 1'b0;
                  a_q         <= '0;
                  q1_q        <= 1'b0;
                  if (ctrl_mult) begin
                     op_q    <= OP_MUL;
                     q_q     <= operand_b;
                     m_q     <= operand_a;
                     state_q <= MUL;
                  end else begin
                     op_q      <= OP_DIV;
                     q_q       <= operand_a;
                     m_q       <= operand_b;
                     neg_b_q   <= operand_b[WIDTH-1];
                     neg_q_q   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                     div_exc_q <= (operand_a == INT_MIN) && (operand_b == '1);
                     if (operand_b == '0) begin
                        result_q     <= '0;
                        exception_q  <= 1'b1;
                        result_rdy_q <= 1'b1;
                        state_q      <= DONE;
                     end else if (operand_a[WIDTH-1]) begin
                        state_q <= NEGA;
                     end else if (operand_b[WIDTH-1]) begin
                        state_q <= NEGB;
                     end else begin
                        state_q <= DIV;
                     end
                  end
               end
            end
            MUL, DIV: begin
               a_q  <= a_d;
               q_q  <= q_d;
               q1_q <= q1_d;
               if (cnt_tc) begin
                  if (state_q == DIV && neg_q_q) begin
                     state_q <= NEGQ;
                  end else begin
                     result_q     <= q_d;
                     exception_q  <= exc_fin;
                     result_rdy_q <= 1'b1;
                     state_q      <= DONE;
                  end
               end
            end
            NEGA: begin
               q_q     <= q_d;
               state_q <= neg_b_q ? NEGB : DIV;
            end
            NEGB: begin
               m_q     <= m_d;
               state_q <= DIV;
            end
            NEGQ: begin
               q_q          <= q_d;
               result_q     <= q_d;
               exception_q  <= exc_fin;
               result_rdy_q <= 1'b1;
               state_q      <= DONE;
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result     = result_q;
   assign exception  = exception_q;
   assign result_rdy = result_rdy_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq with a behavioural adder on the as_* ports
// and an arithmetic reference model for product, quotient, exception and latency.
module tb_multdiv_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ctrl_mult = 1'b0;
   logic        ctrl_div = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic [31:0] result, as_a, as_b, as_sum;
   logic        exception, result_rdy, busy, as_cin, as_cout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   // External adder_subtractor: cin=1 subtracts by inverting b and adding 1.
   assign {as_cout, as_sum} = {1'b0, as_a} + {1'b0, (as_cin ? ~as_b : as_b)} + {32'd0, as_cin};

   multdiv_seq dut (
      .clock      (clock),
      .reset      (reset),
      .ctrl_mult  (ctrl_mult),
      .ctrl_div   (ctrl_div),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .result     (result),
      .exception  (exception),
      .result_rdy (result_rdy),
      .busy       (busy),
      .as_a       (as_a),
      .as_b       (as_b),
      .as_cin     (as_cin),
      .as_sum     (as_sum),
      .as_cout    (as_cout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Reference: 64-bit signed arithmetic, quotient truncated toward zero.
   task automatic model(input logic mul, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc, output int lat);
      longint sa, sb, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (mul) begin
         p   = sa * sb;
         res = p[31:0];
         exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
         lat = 33;
      end else if (b == 32'd0) begin
         res = 32'd0;
         exc = 1'b1;
         lat = 1;
      end else begin
         p   = sa / sb;
         res = p[31:0];
         exc = (p > 64'sd2147483647);
         lat = 33 + int'(sa < 0) + int'(sb < 0) + int'((sa < 0) != (sb < 0));
      end
   endtask

   task automatic do_op(input string tag, input logic mul, input logic both,
                        input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic        ee;
      int          el;
      int          cyc;
      model(mul | both, a, b, er, ee, el);
      @(posedge clock); #1;
      ctrl_mult = mul | both;
      ctrl_div  = !mul | both;
      operand_a = a;
      operand_b = b;
      @(posedge clock); #1;
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
      cyc = 1;
      while (!result_rdy && cyc < 60) begin
         ctrl_div  = (cyc == 10);
         ctrl_mult = (cyc == 10);
         @(posedge clock); #1;
         cyc++;
      end
      ctrl_div  = 1'b0;
      ctrl_mult = 1'b0;
      check({tag, "/latency"}, 32'(cyc), 32'(el));
      check({tag, "/result"}, result, er);
      check({tag, "/exception"}, 32'(exception), 32'(ee));
      check({tag, "/busy_at_rdy"}, 32'(busy), 32'd1);
      // A start in the DONE cycle must be ignored.
      ctrl_mult = 1'b1;
      @(posedge clock); #1;
      ctrl_mult = 1'b0;
      check({tag, "/rdy_pulse"}, 32'(result_rdy), 32'd0);
      check({tag, "/idle_after"}, 32'(busy), 32'd0);
      check({tag, "/result_held"}, result, er);
   endtask

   initial begin
      logic        seen;
      logic [31:0] ra, rb;
      #1 reset = 1'b1;
      #1;
      check("reset/result", result, 32'd0);
      check("reset/flags", {28'd0, exception, result_rdy, busy, as_cin}, 32'd0);
      check("reset/as_a", as_a, 32'd0);
      check("reset/as_b", as_b, 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b0;

      do_op("mul_7x-3",       1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      do_op("mul_ovf",        1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
      do_op("div_-7/2",       1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
      do_op("div_5/0",        1'b0, 1'b0, 32'd5, 32'd0);
      do_op("div_min/-1",     1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("both_start",     1'b0, 1'b1, 32'd1234, 32'hFFFF_FF00);
      do_op("div_7/-2",       1'b0, 1'b0, 32'd7, 32'hFFFF_FFFE);
      do_op("div_-9/-3",      1'b0, 1'b0, 32'hFFFF_FFF7, 32'hFFFF_FFFD);
      do_op("div_0/3",        1'b0, 1'b0, 32'd0, 32'd3);
      do_op("mul_min_mplier", 1'b1, 1'b0, 32'd1, 32'h8000_0000);

      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 2 == 0) begin
            ra = 32'($signed(16'($urandom)));
            rb = 32'($signed(16'($urandom)));
         end
         if (ra == 32'h8000_0000) ra = 32'h8000_0001;
         do_op($sformatf("rand_mul%0d", i), 1'b1, 1'b0, ra, rb);
      end
      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 2 == 0) rb = 32'($signed(8'($urandom)));
         do_op($sformatf("rand_div%0d", i), 1'b0, 1'b0, ra, rb);
      end

      // Reset in the middle of a MULT aborts it without a result_rdy.
      @(posedge clock); #1;
      ctrl_mult = 1'b1;
      operand_a = 32'd7;
      operand_b = 32'd9;
      @(posedge clock); #1;
      ctrl_mult = 1'b0;
      repeat (14) @(posedge clock);
      #1 reset = 1'b1;
      #1;
      check("midrst/result", result, 32'd0);
      check("midrst/flags", {28'd0, exception, result_rdy, busy, as_cin}, 32'd0);
      check("midrst/as_a_b", as_a | as_b, 32'd0);
      @(posedge clock); #1 reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock); #1;
         if (result_rdy || busy) seen = 1'b1;
      end
      check("midrst/no_rdy", 32'(seen), 32'd0);
      do_op("after_rst", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd6);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
